// File: rtl/ctrl_seq_pkg.sv
// Shared types and helpers for the control sequencer: state encoding, trap causes,
// and the one-hot dispatch check.
package ctrl_seq_pkg;

    localparam int unsigned STATE_W      = 3;
    localparam int unsigned CAUSE_W      = 2;
    localparam int unsigned INSN_W       = 32;
    localparam int unsigned ONEHOT_MAX_W = 32;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE     = 3'd0,
        ST_FETCH    = 3'd1,
        ST_LOAD_IR  = 3'd2,
        ST_DISPATCH = 3'd3,
        ST_EXEC     = 3'd4,
        ST_TRAP     = 3'd5
    } state_t;

    localparam logic [CAUSE_W-1:0] CAUSE_NONE     = 2'd0;
    localparam logic [CAUSE_W-1:0] CAUSE_ILLEGAL  = 2'd1;
    localparam logic [CAUSE_W-1:0] CAUSE_FETCH_TO = 2'd2;
    localparam logic [CAUSE_W-1:0] CAUSE_EXEC_TO  = 2'd3;

    // True when exactly one bit is set; unit vectors are zero-extended to ONEHOT_MAX_W.
    function automatic logic is_onehot(input logic [ONEHOT_MAX_W-1:0] v);
        return (v != '0) && ((v & (v - ONEHOT_MAX_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/seq_timeout_counter.sv
// Saturating state-residency timer: cleared on state change, counts while enabled,
// flags expiry when the count reaches a nonzero limit (limit 0 never expires).
module seq_timeout_counter
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clear,
    input  logic         i_enable,
    input  logic [W-1:0] i_limit,
    output logic         o_expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable && (r_count != {W{1'b1}})) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_expired = (i_limit != '0) && (r_count == i_limit);

endmodule

// File: rtl/control_sequencer.sv
// Top-level multi-cycle sequencer: fetch handshake, IR load, one-hot dispatch, exec wait,
// traps, graceful halt, retire count. Perf counters enabled by CTRL_SEQ_PERF_COUNTERS_EN.
module control_sequencer
    import ctrl_seq_pkg::*;
#(
    parameter int unsigned NUM_UNITS    = 4,
    parameter int unsigned MEM_TIMEOUT  = 255,
    parameter int unsigned EXEC_TIMEOUT = 1023,
    parameter int unsigned CNT_W        = 64
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 halt_req,
    output logic                 memory_start,
    input  logic                 memory_done,
    input  logic [INSN_W-1:0]    mem_rdata,
    output logic [INSN_W-1:0]    insn,
    output logic                 load_ins,
    input  logic [NUM_UNITS-1:0] unit_sel,
    input  logic                 illegal,
    output logic [NUM_UNITS-1:0] unit_start,
    output logic [NUM_UNITS-1:0] unit_active,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic                 busy,
    output logic                 trap,
    output logic [CAUSE_W-1:0]   trap_cause,
    output logic [CNT_W-1:0]     retired_count,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     fetch_stall_count
);

    localparam int unsigned TMR_MAX = (MEM_TIMEOUT > EXEC_TIMEOUT) ? MEM_TIMEOUT : EXEC_TIMEOUT;
    localparam int unsigned TMR_W   = (TMR_MAX == 0) ? 1 : $clog2(TMR_MAX + 1);

    state_t               r_state;
    state_t               w_state_next;
    logic [INSN_W-1:0]    r_insn;
    logic [NUM_UNITS-1:0] r_unit_active;
    logic [NUM_UNITS-1:0] w_unit_active_next;
    logic [NUM_UNITS-1:0] w_unit_start;
    logic [CAUSE_W-1:0]   r_trap_cause;
    logic [CAUSE_W-1:0]   w_trap_cause_next;
    logic [CNT_W-1:0]     r_retired;
    logic                 r_halt_pending;
    logic                 w_retire;
    logic                 w_busy;
    logic                 w_exec_done;
    logic                 w_sel_onehot;
    logic                 w_tmr_en;
    logic                 w_tmr_clr;
    logic                 w_tmr_expired;
    logic [TMR_W-1:0]     w_tmr_limit;

    // Only the owning unit's done bit can end EXEC.
    assign w_exec_done  = |(unit_done & r_unit_active);
    assign w_sel_onehot = is_onehot(ONEHOT_MAX_W'(unit_sel));
    assign w_busy       = (r_state != ST_IDLE) && (r_state != ST_TRAP);

    assign w_tmr_en    = (r_state == ST_FETCH) || (r_state == ST_EXEC);
    assign w_tmr_clr   = (w_state_next != r_state);
    assign w_tmr_limit = (r_state == ST_EXEC) ? TMR_W'(EXEC_TIMEOUT) : TMR_W'(MEM_TIMEOUT);

    seq_timeout_counter #(
        .W (TMR_W)
    ) u_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_tmr_clr),
        .i_enable  (w_tmr_en),
        .i_limit   (w_tmr_limit),
        .o_expired (w_tmr_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, dispatch pulse and register updates; done beats timeout in EXEC.
    always_comb begin
        w_state_next       = r_state;
        w_trap_cause_next  = r_trap_cause;
        w_unit_active_next = r_unit_active;
        w_unit_start       = '0;
        w_retire           = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start && !halt_req) w_state_next = ST_FETCH;
            end
            ST_FETCH: begin
                if (memory_done) begin
                    w_state_next = ST_LOAD_IR;
                end else if (w_tmr_expired) begin
                    w_state_next      = ST_TRAP;
                    w_trap_cause_next = CAUSE_FETCH_TO;
                end
            end
            ST_LOAD_IR: begin
                w_state_next = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                if (illegal || !w_sel_onehot) begin
                    w_state_next      = ST_TRAP;
                    w_trap_cause_next = CAUSE_ILLEGAL;
                end else begin
                    w_unit_start       = unit_sel;
                    w_unit_active_next = unit_sel;
                    w_state_next       = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (w_exec_done) begin
                    w_retire           = 1'b1;
                    w_unit_active_next = '0;
                    w_state_next       = (r_halt_pending || halt_req) ? ST_IDLE : ST_FETCH;
                end else if (w_tmr_expired) begin
                    w_unit_active_next = '0;
                    w_state_next       = ST_TRAP;
                    w_trap_cause_next  = CAUSE_EXEC_TO;
                end
            end
            ST_TRAP: begin
                w_unit_active_next = '0;
                if (start) begin
                    w_state_next      = ST_IDLE;
                    w_trap_cause_next = CAUSE_NONE;
                end
            end
            default: begin
                w_state_next       = ST_IDLE;
                w_unit_active_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_insn         <= '0;
            r_unit_active  <= '0;
            r_trap_cause   <= CAUSE_NONE;
            r_retired      <= '0;
            r_halt_pending <= 1'b0;
        end else begin
            if (r_state == ST_LOAD_IR) r_insn <= mem_rdata;
            r_unit_active <= w_unit_active_next;
            r_trap_cause  <= w_trap_cause_next;
            if (w_retire) r_retired <= r_retired + CNT_W'(1);
            if ((w_state_next == ST_IDLE) && (r_state != ST_IDLE)) begin
                r_halt_pending <= 1'b0;
            end else if (halt_req && w_busy) begin
                r_halt_pending <= 1'b1;
            end
        end
    end

    assign memory_start  = (r_state == ST_FETCH);
    assign load_ins      = (r_state == ST_LOAD_IR);
    assign trap          = (r_state == ST_TRAP);
    assign busy          = w_busy;
    assign insn          = r_insn;
    assign unit_start    = w_unit_start;
    assign unit_active   = r_unit_active;
    assign trap_cause    = r_trap_cause;
    assign retired_count = r_retired;

`ifdef CTRL_SEQ_PERF_COUNTERS_EN
    logic [CNT_W-1:0] r_cycle_count;
    logic [CNT_W-1:0] r_fetch_stall_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cycle_count       <= '0;
            r_fetch_stall_count <= '0;
        end else begin
            if (w_busy) r_cycle_count <= r_cycle_count + CNT_W'(1);
            if ((r_state == ST_FETCH) && !memory_done) begin
                r_fetch_stall_count <= r_fetch_stall_count + CNT_W'(1);
            end
        end
    end

    assign cycle_count       = r_cycle_count;
    assign fetch_stall_count = r_fetch_stall_count;
`else
    assign cycle_count       = '0;
    assign fetch_stall_count = '0;
`endif

endmodule

// File: tb/tb_control_sequencer.sv
// Directed self-checking bench for control_sequencer (NUM_UNITS=4, both timeouts 8).
module tb_control_sequencer;

    localparam int unsigned NU = 4;
    localparam int unsigned CW = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          halt_req = 1'b0;
    logic          memory_start;
    logic          memory_done = 1'b0;
    logic [31:0]   mem_rdata = '0;
    logic [31:0]   insn;
    logic          load_ins;
    logic [NU-1:0] unit_sel = '0;
    logic          illegal = 1'b0;
    logic [NU-1:0] unit_start;
    logic [NU-1:0] unit_active;
    logic [NU-1:0] unit_done = '0;
    logic          busy;
    logic          trap;
    logic [1:0]    trap_cause;
    logic [CW-1:0] retired_count;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] fetch_stall_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    control_sequencer #(
        .NUM_UNITS    (NU),
        .MEM_TIMEOUT  (8),
        .EXEC_TIMEOUT (8),
        .CNT_W        (CW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .halt_req          (halt_req),
        .memory_start      (memory_start),
        .memory_done       (memory_done),
        .mem_rdata         (mem_rdata),
        .insn              (insn),
        .load_ins          (load_ins),
        .unit_sel          (unit_sel),
        .illegal           (illegal),
        .unit_start        (unit_start),
        .unit_active       (unit_active),
        .unit_done         (unit_done),
        .busy              (busy),
        .trap              (trap),
        .trap_cause        (trap_cause),
        .retired_count     (retired_count),
        .cycle_count       (cycle_count),
        .fetch_stall_count (fetch_stall_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        start       = 1'b0;
        halt_req    = 1'b0;
        memory_done = 1'b0;
        mem_rdata   = '0;
        unit_sel    = '0;
        illegal     = 1'b0;
        unit_done   = '0;
        reset       = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // From IDLE: start, immediate fetch of word, stops sampling in DISPATCH with sel applied.
    task automatic drive_to_dispatch(input logic [31:0] word, input logic [NU-1:0] sel);
        start = 1'b1;
        tick();
        start       = 1'b0;
        memory_done = 1'b1;
        mem_rdata   = word;
        tick();
        memory_done = 1'b0;
        unit_sel    = sel;
        tick();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (busy !== 1'b0 || trap !== 1'b0) begin errors++; $display("FAIL reset_state: busy=%b trap=%b expected 0 0", busy, trap); end
        checks++; if (memory_start !== 1'b0 || load_ins !== 1'b0) begin errors++; $display("FAIL reset_strobes: mem_start=%b load_ins=%b expected 0 0", memory_start, load_ins); end
        checks++; if (unit_start !== 4'b0 || unit_active !== 4'b0) begin errors++; $display("FAIL reset_units: start=%b active=%b expected 0000", unit_start, unit_active); end
        checks++; if (insn !== 32'h0 || trap_cause !== 2'd0) begin errors++; $display("FAIL reset_regs: insn=%h cause=%0d expected 0", insn, trap_cause); end
        checks++; if (retired_count !== 16'd0 || cycle_count !== 16'd0 || fetch_stall_count !== 16'd0) begin
            errors++; $display("FAIL reset_counters: ret=%0d cyc=%0d stall=%0d expected 0", retired_count, cycle_count, fetch_stall_count);
        end
    endtask

    task automatic test_basic();
        logic [CW-1:0] exp_cyc;
        logic [CW-1:0] exp_stall;
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++; if (memory_start !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL basic_fetch: mem_start=%b busy=%b expected 1 1", memory_start, busy); end
        repeat (3) tick();
        memory_done = 1'b1;
        mem_rdata   = 32'h00A00093;
        tick();
        memory_done = 1'b0;
        unit_sel    = 4'b0001;
        checks++; if (load_ins !== 1'b1 || memory_start !== 1'b0) begin errors++; $display("FAIL basic_load_ir: load_ins=%b mem_start=%b expected 1 0", load_ins, memory_start); end
        tick();
        checks++; if (insn !== 32'h00A00093) begin errors++; $display("FAIL basic_insn: got %h expected 00a00093", insn); end
        checks++; if (unit_start !== 4'b0001) begin errors++; $display("FAIL basic_dispatch_pulse: got %b expected 0001", unit_start); end
        tick();
        checks++; if (unit_start !== 4'b0000 || unit_active !== 4'b0001) begin errors++; $display("FAIL basic_exec: start=%b active=%b expected 0000 0001", unit_start, unit_active); end
        tick();
        unit_done = 4'b0001;
        checks++; if (retired_count !== 16'd0) begin errors++; $display("FAIL basic_no_early_retire: got %0d expected 0", retired_count); end
        tick();
        unit_done = 4'b0000;
        checks++; if (retired_count !== 16'd1) begin errors++; $display("FAIL basic_retired: got %0d expected 1", retired_count); end
        checks++; if (memory_start !== 1'b1 || unit_active !== 4'b0) begin errors++; $display("FAIL basic_refetch: mem_start=%b active=%b expected 1 0000", memory_start, unit_active); end
`ifdef CTRL_SEQ_PERF_COUNTERS_EN
        exp_cyc   = 16'd8;
        exp_stall = 16'd3;
`else
        exp_cyc   = 16'd0;
        exp_stall = 16'd0;
`endif
        checks++; if (cycle_count !== exp_cyc || fetch_stall_count !== exp_stall) begin
            errors++; $display("FAIL basic_perf: cyc=%0d stall=%0d expected %0d %0d", cycle_count, fetch_stall_count, exp_cyc, exp_stall);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        memory_done = 1'b1;
        mem_rdata   = 32'h12345678;
        unit_sel    = 4'b1000;
        unit_done   = 4'b1000;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (12) tick();
        checks++; if (retired_count !== 16'd3) begin errors++; $display("FAIL b2b_retired: got %0d expected 3", retired_count); end
        checks++; if (memory_start !== 1'b1 || insn !== 32'h12345678) begin errors++; $display("FAIL b2b_state: mem_start=%b insn=%h expected 1 12345678", memory_start, insn); end
    endtask

    task automatic test_illegal();
        logic [NU-1:0] sel;
        logic          ill;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            case (k)
                0:       begin sel = 4'b0110; ill = 1'b0; end
                1:       begin sel = 4'b0001; ill = 1'b1; end
                default: begin sel = 4'b0000; ill = 1'b0; end
            endcase
            illegal = ill;
            drive_to_dispatch(32'h00000013 + 32'(k), sel);
            checks++; if (unit_start !== 4'b0000) begin errors++; $display("FAIL illegal_no_pulse[%0d]: got %b expected 0000", k, unit_start); end
            tick();
            illegal = 1'b0;
            checks++; if (trap !== 1'b1 || trap_cause !== 2'd1 || busy !== 1'b0) begin
                errors++; $display("FAIL illegal_trap[%0d]: trap=%b cause=%0d busy=%b expected 1 1 0", k, trap, trap_cause, busy);
            end
            tick();
            checks++; if (trap !== 1'b1 || unit_active !== 4'b0) begin errors++; $display("FAIL illegal_hold[%0d]: trap=%b active=%b expected 1 0000", k, trap, unit_active); end
            start = 1'b1;
            tick();
            start = 1'b0;
            checks++; if (trap !== 1'b0 || trap_cause !== 2'd0 || busy !== 1'b0) begin
                errors++; $display("FAIL illegal_ack[%0d]: trap=%b cause=%0d busy=%b expected 0 0 0", k, trap, trap_cause, busy);
            end
        end
        checks++; if (retired_count !== 16'd0) begin errors++; $display("FAIL illegal_retired: got %0d expected 0", retired_count); end
    endtask

    task automatic test_fetch_timeout();
        int n;
        logic [CW-1:0] exp_stall;
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (memory_start === 1'b1 && n < 50) begin
            n++;
            tick();
        end
        checks++; if (n != 9) begin errors++; $display("FAIL fetch_to_cycles: got %0d expected 9", n); end
        checks++; if (trap !== 1'b1 || trap_cause !== 2'd2) begin errors++; $display("FAIL fetch_to_trap: trap=%b cause=%0d expected 1 2", trap, trap_cause); end
`ifdef CTRL_SEQ_PERF_COUNTERS_EN
        exp_stall = 16'd9;
`else
        exp_stall = 16'd0;
`endif
        checks++; if (fetch_stall_count !== exp_stall) begin errors++; $display("FAIL fetch_to_stall: got %0d expected %0d", fetch_stall_count, exp_stall); end
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_exec_timeout();
        int n;
        apply_reset();
        drive_to_dispatch(32'h00000033, 4'b0010);
        tick();
        unit_done = 4'b0100;
        n = 0;
        while (unit_active === 4'b0010 && n < 50) begin
            n++;
            tick();
        end
        checks++; if (n != 9) begin errors++; $display("FAIL exec_to_cycles: got %0d expected 9", n); end
        checks++; if (trap !== 1'b1 || trap_cause !== 2'd3 || retired_count !== 16'd0) begin
            errors++; $display("FAIL exec_to_trap: trap=%b cause=%0d ret=%0d expected 1 3 0", trap, trap_cause, retired_count);
        end
        start = 1'b1;
        tick();
        start     = 1'b0;
        unit_done = 4'b0000;
        drive_to_dispatch(32'h00000033, 4'b0010);
        tick();
        unit_done = 4'b0100;
        repeat (8) tick();
        checks++; if (unit_active !== 4'b0010 || trap !== 1'b0) begin errors++; $display("FAIL exec_to_edge: active=%b trap=%b expected 0010 0", unit_active, trap); end
        unit_done = 4'b0110;
        tick();
        unit_done = 4'b0000;
        checks++; if (trap !== 1'b0 || retired_count !== 16'd1 || memory_start !== 1'b1) begin
            errors++; $display("FAIL exec_done_wins: trap=%b ret=%0d mem_start=%b expected 0 1 1", trap, retired_count, memory_start);
        end
    endtask

    task automatic test_halt();
        apply_reset();
        start = 1'b1;
        tick();
        start       = 1'b0;
        memory_done = 1'b1;
        mem_rdata   = 32'h00B00113;
        tick();
        memory_done = 1'b0;
        halt_req    = 1'b1;
        unit_sel    = 4'b0100;
        tick();
        halt_req = 1'b0;
        checks++; if (busy !== 1'b1 || unit_start !== 4'b0100) begin errors++; $display("FAIL halt_dispatch: busy=%b start=%b expected 1 0100", busy, unit_start); end
        tick();
        unit_done = 4'b0100;
        tick();
        unit_done = 4'b0000;
        checks++; if (busy !== 1'b0 || memory_start !== 1'b0 || retired_count !== 16'd1) begin
            errors++; $display("FAIL halt_idle: busy=%b mem_start=%b ret=%0d expected 0 0 1", busy, memory_start, retired_count);
        end
        start    = 1'b1;
        halt_req = 1'b1;
        tick();
        start    = 1'b0;
        halt_req = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL halt_blocks_start: busy=%b expected 0", busy); end
    endtask

    task automatic test_async_reset();
        apply_reset();
        memory_done = 1'b1;
        mem_rdata   = 32'h00C00193;
        unit_sel    = 4'b0001;
        unit_done   = 4'b0001;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        unit_done = 4'b0000;
        repeat (3) tick();
        checks++; if (unit_active !== 4'b0001 || retired_count !== 16'd1) begin
            errors++; $display("FAIL areset_pre: active=%b ret=%0d expected 0001 1", unit_active, retired_count);
        end
        #2;
        reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || unit_active !== 4'b0 || memory_start !== 1'b0) begin
            errors++; $display("FAIL areset_outputs: busy=%b active=%b mem_start=%b expected 0 0000 0", busy, unit_active, memory_start);
        end
        checks++; if (retired_count !== 16'd0 || insn !== 32'h0 || cycle_count !== 16'd0 || fetch_stall_count !== 16'd0) begin
            errors++; $display("FAIL areset_regs: ret=%0d insn=%h cyc=%0d stall=%0d expected 0", retired_count, insn, cycle_count, fetch_stall_count);
        end
        memory_done = 1'b0;
        unit_sel    = '0;
        tick();
        reset = 1'b0;
        tick();
        checks++; if (busy !== 1'b0 || trap !== 1'b0) begin errors++; $display("FAIL areset_idle: busy=%b trap=%b expected 0 0", busy, trap); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_illegal();
        test_fetch_timeout();
        test_exec_timeout();
        test_halt();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
Parametrised top-level sequencer for the multi-cycle RV64F core. It fetches over a start/done memory handshake, latches the instruction register and dispatches one-cycle start pulses to NUM_UNITS execution FSMs (ALU, branch/jump, load/store, FPU, ...). It then waits for the owning unit's done. Beyond its predecessor, it adds:
- one-hot dispatch validation
- illegal-instruction, fetch-timeout and exec-timeout traps
- graceful halt
- retired-instruction counter

Parameters:
NUM_UNITS, 4, number of execution FSMs (bit i of unit_* vectors = unit i)
MEM_TIMEOUT, 255, max cycles in FETCH before trap; 0 disables
EXEC_TIMEOUT, 1023, max cycles in EXEC before trap; 0 disables
CNT_W, 64, width of retired/perf counters

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  leave IDLE (or acknowledge TRAP)
halt_req  in  1  stop after current instruction retires
memory_start  out  1  fetch request, level while in FETCH
memory_done  in  1  fetch complete, sampled in FETCH
mem_rdata  in  32  fetched instruction word
insn  out  32  instruction register
load_ins  out  1  high in LOAD_IR
unit_sel  in  NUM_UNITS  decoder one-hot unit select (combinational from insn)
illegal  in  1  decoder illegal-opcode flag
unit_start  out  NUM_UNITS  one-cycle dispatch pulse
unit_active  out  NUM_UNITS  owning unit, level through EXEC
unit_done  in  NUM_UNITS  per-unit completion
busy  out  1  state not IDLE and not TRAP
trap  out  1  high in TRAP
trap_cause  out  2  1 illegal/bad select, 2 fetch timeout, 3 exec timeout, 0 none
retired_count  out  CNT_W  instructions completed, wraps
cycle_count  out  CNT_W  optional perf counter
fetch_stall_count  out  CNT_W  optional perf counter

Behaviour:
- Reset (async, any state): state IDLE; all outputs 0; insn=0; counters 0; halt_pending=0; timer 0.
- IDLE: start=1 and halt_req=0 -> FETCH. If halt_req=1, start is ignored.
- FETCH: memory_start=1.
  - memory_done=1 -> LOAD_IR.
  - Otherwise, when timer==MEM_TIMEOUT (nonzero) -> TRAP, cause 2.
- LOAD_IR: load_ins=1; insn<=mem_rdata at clock edge; -> DISPATCH.
- DISPATCH:
  - illegal=1, or unit_sel zero/multi-hot -> TRAP, cause 1.
  - Else unit_start=unit_sel for exactly this cycle; unit_active<=unit_sel; -> EXEC.
- EXEC: unit_active held. Only unit_done & unit_active counts; other done bits are ignored.
  - On done: retired_count+1; unit_active<=0; -> IDLE if halt_pending or halt_req, else FETCH.
  - Timer==EXEC_TIMEOUT (nonzero) -> TRAP, cause 3.
  - done and timeout in the same cycle: done wins.
- TRAP: trap=1; trap_cause held; unit_active=0. start=1 -> IDLE, and trap_cause clears to 0.
- Latency: minimum 4 cycles per instruction (FETCH, LOAD_IR, DISPATCH, EXEC, each 1 cycle when done is immediate).
- Timer:
  - Clears on every state change.
  - Increments while in FETCH/EXEC; saturates at max.
  - Width $clog2(max(MEM_TIMEOUT,EXEC_TIMEOUT)+1).
- halt_pending:
  - Sets when halt_req=1 in any state other than IDLE/TRAP.
  - Clears on entering IDLE.
- memory_done outside FETCH and unit_done outside EXEC: ignored.

Optional Feature:
CTRL_SEQ_PERF_COUNTERS_EN
- Defined:
  - cycle_count increments every cycle busy=1.
  - fetch_stall_count increments every FETCH cycle with memory_done=0.
  - Both wrap and clear on reset.
- Undefined: both ports present and driven constant 0; no counter flops.

Decomposition:
- Package ctrl_seq_pkg:
  - state encoding: IDLE 0, FETCH 1, LOAD_IR 2, DISPATCH 3, EXEC 4, TRAP 5 (3-bit)
  - trap cause constants CAUSE_NONE/ILLEGAL/FETCH_TO/EXEC_TO
  - one-hot check function
- Sub-module seq_timeout_counter: clear, enable, limit; saturating; expired flag.

Test Plan:
- Use NUM_UNITS=4. Sequence: start pulse; memory_done after 3 FETCH cycles; mem_rdata=0x00A00093; unit_sel=4'b0001; unit_done[0] 2 cycles after start.
  -> insn=0x00A00093; unit_start=0001 for 1 cycle; retired_count=1; back in FETCH.
- In DISPATCH, unit_sel=4'b0110 (or illegal=1) -> TRAP, trap_cause=1, no unit_start pulse. Then start=1 -> IDLE, trap_cause=0.
- MEM_TIMEOUT=8, memory_done never asserted -> TRAP with trap_cause=2 at the 9th FETCH cycle.
- EXEC_TIMEOUT=8, no done. Separately, assert unit_done[2] while unit 1 is active.
  -> Stray done is ignored; TRAP with trap_cause=3. unit_done[1] on the timeout cycle -> retires instead.
- halt_req pulsed in LOAD_IR -> instruction completes, retired_count increments, state IDLE, busy=0.
- Reset asserted mid-EXEC, async between clock edges -> outputs 0 immediately; state IDLE; retired_count=0. Perf counters (macro defined) also 0.
